bus_timer_device: RTL and testbench

Memory-mapped 64-bit timer that sits on one device port of the shared bus and acts as a responder (slave).
- Accepts the device-side request/address/write-enable/write-data signals the bus drives; returns read data registered one cycle later, matching the bus response timing.
- Provides a free-running prescaled counter (mtime), a compare register (mtimecmp) and a level interrupt to a host.

---
 rtl/bus_timer_pkg.sv | 18 +
 rtl/bus_timer_prescaler.sv | 29 ++
 rtl/bus_timer_device.sv | 123 ++++++++++++
 tb/tb_bus_timer_device.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/bus_timer_pkg.sv
// Shared register map and reset constants for the memory-mapped 64-bit bus timer.
package bus_timer_pkg;

    localparam logic [2:0] OFF_CTRL        = 3'd0;
    localparam logic [2:0] OFF_PRESCALE    = 3'd1;
    localparam logic [2:0] OFF_MTIME_LO    = 3'd2;
    localparam logic [2:0] OFF_MTIME_HI    = 3'd3;
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd4;
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd5;
    localparam logic [2:0] OFF_STATUS      = 3'd6;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    localparam logic [63:0] MTIME_RST    = 64'h0;
    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/bus_timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every (prescale_i + 1) enabled cycles.
module bus_timer_prescaler #(
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [PrescaleWidth-1:0] prescale_i,
    input  logic                     clr_i,
    output logic                     tick_o
);

    logic [PrescaleWidth-1:0] cnt_q, cnt_d;

    // A clear (PRESCALE rewrite) restarts the period and suppresses that cycle's tick.
    always_comb begin
        tick_o = en_i & ~clr_i & (cnt_q == prescale_i);
        cnt_d  = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (tick_o) cnt_d = '0;
        else if (en_i)   cnt_d = cnt_q + PrescaleWidth'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/bus_timer_device.sv
// Bus-attached 64-bit timer: register file, read mux, compare and level interrupt.
// Optional tear-free MTIME_HI reads via shadow register: define BUS_TIMER_HI_SHADOW_EN.
module bus_timer_device
    import bus_timer_pkg::*;
#(
    parameter int unsigned AddressWidth  = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned PrescaleWidth = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    device_req_i,
    input  logic [AddressWidth-1:0] device_addr_i,
    input  logic                    device_we_i,
    input  logic [DataWidth-1:0]    device_wdata_i,
    output logic [DataWidth-1:0]    device_rdata_o,
    output logic                    timer_irq_o
);

    if (DataWidth != 32) begin : g_bad_dw
        $error("bus_timer_device: only DataWidth=32 is supported");
    end

    logic [1:0]               ctrl_q, ctrl_d;
    logic [PrescaleWidth-1:0] prescale_q, prescale_d;
    logic [63:0]              mtime_q, mtime_d, mtime_inc;
    logic [63:0]              mtimecmp_q, mtimecmp_d;
    logic [DataWidth-1:0]     rdata_q, rdata_d;
    logic                     irq_q;
    logic [2:0]               off;
    logic                     wr, rd, tick, cmp_hit, presc_clr;
    logic [DataWidth-1:0]     mtime_hi_rd;

    // Base/mask matching is done by the bus; the remaining address bits are don't-care.
    logic unused_addr;
    assign unused_addr = ^{device_addr_i[AddressWidth-1:5], device_addr_i[1:0]};

    assign off       = device_addr_i[4:2];
    assign wr        = device_req_i & device_we_i;
    assign rd        = device_req_i & ~device_we_i;
    assign presc_clr = wr && (off == OFF_PRESCALE);
    assign cmp_hit   = (mtime_q >= mtimecmp_q);
    assign mtime_inc = tick ? mtime_q + 64'd1 : mtime_q;

    bus_timer_prescaler #(.PrescaleWidth(PrescaleWidth)) u_prescaler (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (ctrl_q[CTRL_EN]),
        .prescale_i (prescale_q),
        .clr_i      (presc_clr),
        .tick_o     (tick)
    );

`ifdef BUS_TIMER_HI_SHADOW_EN
    logic [31:0] hi_shadow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                              hi_shadow_q <= '0;
        else if (rd && (off == OFF_MTIME_LO))   hi_shadow_q <= mtime_q[63:32];
    end

    assign mtime_hi_rd = hi_shadow_q;
`else
    assign mtime_hi_rd = mtime_q[63:32];
`endif

    // A half-word write on a tick keeps the other half's incremented value.
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        mtime_d    = mtime_inc;
        mtimecmp_d = mtimecmp_q;
        if (wr) begin
            case (off)
                OFF_CTRL:        ctrl_d             = device_wdata_i[1:0];
                OFF_PRESCALE:    prescale_d         = PrescaleWidth'(device_wdata_i);
                OFF_MTIME_LO:    mtime_d[31:0]      = device_wdata_i;
                OFF_MTIME_HI:    mtime_d[63:32]     = device_wdata_i;
                OFF_MTIMECMP_LO: mtimecmp_d[31:0]   = device_wdata_i;
                OFF_MTIMECMP_HI: mtimecmp_d[63:32]  = device_wdata_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        if (rd) begin
            case (off)
                OFF_CTRL:        rdata_d = DataWidth'(ctrl_q);
                OFF_PRESCALE:    rdata_d = DataWidth'(prescale_q);
                OFF_MTIME_LO:    rdata_d = mtime_q[31:0];
                OFF_MTIME_HI:    rdata_d = mtime_hi_rd;
                OFF_MTIMECMP_LO: rdata_d = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI: rdata_d = mtimecmp_q[63:32];
                OFF_STATUS:      rdata_d = DataWidth'(cmp_hit);
                default:         rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            mtime_q    <= MTIME_RST;
            mtimecmp_q <= MTIMECMP_RST;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            irq_q      <= ctrl_q[CTRL_IRQ_EN] & cmp_hit;
        end
    end

    assign device_rdata_o = rdata_q;
    assign timer_irq_o    = irq_q;

endmodule

// File: tb/tb_bus_timer_device.sv
// Directed self-checking bench for bus_timer_device (honours BUS_TIMER_HI_SHADOW_EN).
module tb_bus_timer_device;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        device_req_i = 1'b0;
    logic [31:0] device_addr_i = '0;
    logic        device_we_i = 1'b0;
    logic [31:0] device_wdata_i = '0;
    logic [31:0] device_rdata_o;
    logic        timer_irq_o;

    int tests = 0;
    int fails = 0;

    bus_timer_device dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .device_req_i   (device_req_i),
        .device_addr_i  (device_addr_i),
        .device_we_i    (device_we_i),
        .device_wdata_i (device_wdata_i),
        .device_rdata_o (device_rdata_o),
        .timer_irq_o    (timer_irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        device_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] data);
        device_req_i = 1'b1;
        device_we_i = 1'b1;
        device_addr_i = {27'h0, off, 2'b00};
        device_wdata_i = data;
        @(posedge clk_i);
        #1 device_req_i = 1'b0;
        device_we_i = 1'b0;
    endtask

    task automatic rd(input logic [2:0] off, input logic [31:0] exp, input string tag);
        device_req_i = 1'b1;
        device_we_i = 1'b0;
        device_addr_i = {27'h0, off, 2'b00};
        @(posedge clk_i);
        #1 device_req_i = 1'b0;
        check(tag, device_rdata_o, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    logic [31:0] exp_hi;

    initial begin
        // 1: reset values and register map
        do_reset();
        check("rst_rdata", device_rdata_o, 32'h0);
        check("rst_irq", {31'h0, timer_irq_o}, 32'h0);
        rd(3'd0, 32'h0, "rst_ctrl");
        rd(3'd1, 32'h0, "rst_prescale");
        rd(3'd2, 32'h0, "rst_mtime_lo");
        rd(3'd3, 32'h0, "rst_mtime_hi");
        rd(3'd4, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(3'd5, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(3'd6, 32'h0, "rst_status");
        rd(3'd7, 32'h0, "rst_unmapped");
        idle(1);
        check("idle_rdata_zero", device_rdata_o, 32'h0);
        wr(3'd7, 32'h1234_5678);
        rd(3'd7, 32'h0, "unmapped_wr_ignored");
        wr(3'd0, 32'hFFFF_FFFC);
        rd(3'd0, 32'h0, "ctrl_upper_bits");

        // 2: prescale 3 -> one tick per 4 cycles, 10 ticks in 40 idle cycles
        do_reset();
        wr(3'd1, 32'd3);
        wr(3'd0, 32'd1);
        idle(40);
        rd(3'd2, 32'd10, "presc3_mtime");
        rd(3'd1, 32'd3, "presc3_readback");
        check("presc3_no_irq", {31'h0, timer_irq_o}, 32'h0);

        // 3: compare interrupt timing
        do_reset();
        wr(3'd5, 32'h0);
        wr(3'd4, 32'd20);
        wr(3'd0, 32'd3);
        wr(3'd1, 32'd0);
        idle(20);
        check("irq_before_hit", {31'h0, timer_irq_o}, 32'h0);
        idle(1);
        check("irq_after_hit", {31'h0, timer_irq_o}, 32'h1);
        rd(3'd6, 32'h1, "status_hit");
        wr(3'd4, 32'd100);
        check("irq_on_cmp_write", {31'h0, timer_irq_o}, 32'h1);
        idle(1);
        check("irq_dropped", {31'h0, timer_irq_o}, 32'h0);

        // 4 + 6: carry from LO into HI, then full 64-bit wrap
        do_reset();
        wr(3'd3, 32'h0);
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd1, 32'd0);
        wr(3'd0, 32'd1);
        rd(3'd2, 32'hFFFF_FFFF, "carry_lo_pre");
`ifdef BUS_TIMER_HI_SHADOW_EN
        exp_hi = 32'h0;
`else
        exp_hi = 32'h1;
`endif
        rd(3'd3, exp_hi, "carry_hi");
        rd(3'd2, 32'h1, "carry_lo_post");
        wr(3'd0, 32'd0);
        wr(3'd3, 32'hFFFF_FFFF);
        wr(3'd2, 32'hFFFF_FFFF);
        wr(3'd0, 32'd1);
        rd(3'd2, 32'hFFFF_FFFF, "wrap_lo_pre");
        rd(3'd2, 32'h0, "wrap_lo_post");
        rd(3'd3, 32'h0, "wrap_hi_post");

        // 5: write on tick, back-to-back access, EN cleared on a tick
        do_reset();
        wr(3'd0, 32'd1);
        wr(3'd2, 32'd5);
        rd(3'd2, 32'd5, "wr_on_tick");
        rd(3'd2, 32'd6, "next_tick");
        rd(3'd2, 32'd7, "b2b_rd1");
        wr(3'd2, 32'd100);
        check("rdata_zero_on_write", device_rdata_o, 32'h0);
        rd(3'd2, 32'd100, "b2b_rd2");
        wr(3'd0, 32'd0);
        rd(3'd2, 32'd102, "en_clr_tick_kept");
        rd(3'd2, 32'd102, "en_clr_hold");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
